// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, states,
// instruction classes, ALUOp, PCSrc and RegDst selects.
package ctrl_pkg;

   localparam int unsigned OPC_W = 6;
   localparam int unsigned STATE_W = 4;

   localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
   localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
   localparam logic [OPC_W-1:0] OP_ADDIU = 6'b000010;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'b010000;
   localparam logic [OPC_W-1:0] OP_AND   = 6'b010001;
   localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
   localparam logic [OPC_W-1:0] OP_OR    = 6'b010011;
   localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
   localparam logic [OPC_W-1:0] OP_SLTI  = 6'b100110;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
   localparam logic [OPC_W-1:0] OP_BLTZ  = 6'b110110;
   localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
   localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
   localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;
   localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

   typedef enum logic [STATE_W-1:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_LS = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB_LD  = 4'b0100,
      S_EXE_BR = 4'b0101,
      S_EXE_AL = 4'b0110,
      S_WB_AL  = 4'b0111,
      S_HALT   = 4'b1000
   } state_t;

   typedef enum logic [3:0] {
      C_AL_R,
      C_AL_I,
      C_BR,
      C_SW,
      C_LW,
      C_J,
      C_JR,
      C_JAL,
      C_HALT,
      C_UNDEF
   } iclass_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: ALU function, operand selects, extension mode and
// instruction class for the control FSM.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] op,
   output logic [2:0]       aluop,
   output logic             extsel,
   output logic             alusrca,
   output logic             alusrcb,
   output iclass_t          iclass
);

   always_comb begin
      aluop   = ALU_ADD;
      extsel  = 1'b1;
      alusrca = 1'b0;
      alusrcb = 1'b0;
      iclass  = C_UNDEF;
      case (op)
         OP_ADD:   iclass = C_AL_R;
         OP_SUB:   begin aluop = ALU_SUB; iclass = C_AL_R; end
         OP_ADDIU: begin alusrcb = 1'b1; iclass = C_AL_I; end
         OP_ANDI:  begin aluop = ALU_AND; extsel = 1'b0; alusrcb = 1'b1; iclass = C_AL_I; end
         OP_AND:   begin aluop = ALU_AND; iclass = C_AL_R; end
         OP_ORI:   begin aluop = ALU_OR; extsel = 1'b0; alusrcb = 1'b1; iclass = C_AL_I; end
         OP_OR:    begin aluop = ALU_OR; iclass = C_AL_R; end
         OP_SLL:   begin aluop = ALU_SLL; alusrca = 1'b1; iclass = C_AL_R; end
         OP_SLTI:  begin aluop = ALU_SLT; alusrcb = 1'b1; iclass = C_AL_I; end
         OP_SW:    begin alusrcb = 1'b1; iclass = C_SW; end
         OP_LW:    begin alusrcb = 1'b1; iclass = C_LW; end
         OP_BEQ,
         OP_BNE:   begin aluop = ALU_SUB; iclass = C_BR; end
         // bltz compares rs against $0; a negative rs gives a nonzero result
         OP_BLTZ:  begin aluop = ALU_SLT; iclass = C_BR; end
         OP_J:     iclass = C_J;
         OP_JR:    iclass = C_JR;
         OP_JAL:   iclass = C_JAL;
         OP_HALT:  iclass = C_HALT;
         default:  iclass = C_UNDEF;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB state sequencer with
// outputs decoded from state, opcode and Zero. CTRL_PERF_EN adds InstCount.
module multi_cycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W = 6,
   parameter int unsigned ST_W = 4
)(
   input  logic            CLK,
   input  logic            Reset,
   input  logic [OP_W-1:0] Op,
   input  logic            Zero,
   output logic [ST_W-1:0] State,
   output logic [2:0]      ALUOp,
   output logic            ALUSrcA,
   output logic            ALUSrcB,
   output logic            ExtSel,
   output logic            PCWre,
   output logic [1:0]      PCSrc,
   output logic            InsMemRW,
   output logic            IRWre,
   output logic            mRD,
   output logic            mWR,
   output logic            RegWre,
   output logic [1:0]      RegDst,
   output logic            WrRegDSrc,
   output logic            DBDataSrc
`ifdef CTRL_PERF_EN
   ,
   output logic [31:0]     InstCount
`endif
);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] dec_aluop;
   logic       dec_extsel;
   logic       dec_alusrca;
   logic       dec_alusrcb;
   iclass_t    dec_iclass;
   logic       br_taken;

   ctrl_decode u_decode (
      .op      (OPC_W'(Op)),
      .aluop   (dec_aluop),
      .extsel  (dec_extsel),
      .alusrca (dec_alusrca),
      .alusrcb (dec_alusrcb),
      .iclass  (dec_iclass)
   );

   always_ff @(posedge CLK) begin
      if (Reset) state <= S_IF;
      else       state <= state_nxt;
   end

   assign State = ST_W'(state);

   // bltz is taken when rs < 0, i.e. the slt result is nonzero
   always_comb begin
      case (OPC_W'(Op))
         OP_BEQ:  br_taken = Zero;
         OP_BNE,
         OP_BLTZ: br_taken = ~Zero;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = S_IF;
      ALUOp     = ALU_ADD;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = dec_extsel;
      PCWre     = 1'b0;
      PCSrc     = PC_NEXT;
      InsMemRW  = 1'b0;
      IRWre     = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      RegWre    = 1'b0;
      RegDst    = RD_RA;
      WrRegDSrc = 1'b0;
      DBDataSrc = 1'b0;
      // Reset suppresses every write so an aborted instruction leaves no trace
      if (Reset) begin
         InsMemRW = 1'b1;
      end else begin
         case (state)
            S_IF: begin
               InsMemRW  = 1'b1;
               IRWre     = 1'b1;
               state_nxt = S_ID;
            end
            S_ID: begin
               case (dec_iclass)
                  C_J: begin
                     PCWre = 1'b1;
                     PCSrc = PC_JUMP;
                  end
                  C_JAL: begin
                     PCWre     = 1'b1;
                     PCSrc     = PC_JUMP;
                     RegWre    = 1'b1;
                     RegDst    = RD_RA;
                     WrRegDSrc = 1'b0;
                  end
                  C_JR: begin
                     PCWre = 1'b1;
                     PCSrc = PC_RS;
                  end
                  C_HALT: state_nxt = S_HALT;
                  C_AL_R,
                  C_AL_I: state_nxt = S_EXE_AL;
                  C_BR:   state_nxt = S_EXE_BR;
                  C_SW,
                  C_LW:   state_nxt = S_EXE_LS;
                  default: PCWre = 1'b1;
               endcase
            end
            S_EXE_AL: begin
               ALUOp     = dec_aluop;
               ALUSrcA   = dec_alusrca;
               ALUSrcB   = dec_alusrcb;
               state_nxt = S_WB_AL;
            end
            S_WB_AL: begin
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               RegDst    = (dec_iclass == C_AL_R) ? RD_RD : RD_RT;
               PCWre     = 1'b1;
            end
            S_EXE_BR: begin
               ALUOp = dec_aluop;
               PCWre = 1'b1;
               PCSrc = br_taken ? PC_BRANCH : PC_NEXT;
            end
            S_EXE_LS: begin
               ALUOp     = ALU_ADD;
               ALUSrcB   = 1'b1;
               state_nxt = S_MEM;
            end
            S_MEM: begin
               if (dec_iclass == C_SW) begin
                  mWR   = 1'b1;
                  PCWre = 1'b1;
               end else begin
                  mRD       = 1'b1;
                  state_nxt = S_WB_LD;
               end
            end
            S_WB_LD: begin
               RegWre    = 1'b1;
               RegDst    = RD_RT;
               DBDataSrc = 1'b1;
               WrRegDSrc = 1'b1;
               PCWre     = 1'b1;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
         endcase
      end
   end

`ifdef CTRL_PERF_EN
   // One PCWre pulse per retired instruction
   always_ff @(posedge CLK) begin
      if (Reset)      InstCount <= 32'd0;
      else if (PCWre) InstCount <= InstCount + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through
// its state sequence and checks decoded controls against hand-computed values.
module tb_multi_cycle_ctrl;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [5:0] Op;
   logic       Zero;
   logic [3:0] State;
   logic [2:0] ALUOp;
   logic       ALUSrcA, ALUSrcB, ExtSel, PCWre;
   logic [1:0] PCSrc;
   logic       InsMemRW, IRWre, mRD, mWR, RegWre;
   logic [1:0] RegDst;
   logic       WrRegDSrc, DBDataSrc;
`ifdef CTRL_PERF_EN
   logic [31:0] InstCount;
`endif

   int total = 0;
   int bad   = 0;

   multi_cycle_ctrl dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Op        (Op),
      .Zero      (Zero),
      .State     (State),
      .ALUOp     (ALUOp),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ExtSel    (ExtSel),
      .PCWre     (PCWre),
      .PCSrc     (PCSrc),
      .InsMemRW  (InsMemRW),
      .IRWre     (IRWre),
      .mRD       (mRD),
      .mWR       (mWR),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .WrRegDSrc (WrRegDSrc),
      .DBDataSrc (DBDataSrc)
`ifdef CTRL_PERF_EN
      ,
      .InstCount (InstCount)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #3;
   endtask

   logic [5:0] br_op  [6] = '{6'b110100, 6'b110100, 6'b110101, 6'b110101, 6'b110110, 6'b110110};
   logic       br_z   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [1:0] br_src [6] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
   logic [2:0] br_alu [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b110, 3'b110};

   initial begin
      Reset = 1'b1;
      Op    = 6'b000000;
      Zero  = 1'b0;
      cyc();
      chk("rst_insmem", 32'(InsMemRW), 32'd1);
      chk("rst_irwre",  32'(IRWre), 32'd0);
      chk("rst_pcwre",  32'(PCWre), 32'd0);
      chk("rst_regwre", 32'(RegWre), 32'd0);
      cyc();
      chk("rst_state", 32'(State), 32'd0);
`ifdef CTRL_PERF_EN
      chk("rst_count", InstCount, 32'd0);
`endif
      Reset = 1'b0;
      #1;

      // add: 0 -> 1 -> 6 -> 7 -> 0
      chk("add_if_state", 32'(State), 32'd0);
      chk("add_if_irwre", 32'(IRWre), 32'd1);
      chk("add_if_insmem", 32'(InsMemRW), 32'd1);
      cyc();
      chk("add_id_state", 32'(State), 32'd1);
      chk("add_id_pcwre", 32'(PCWre), 32'd0);
      chk("add_id_regwre", 32'(RegWre), 32'd0);
      cyc();
      chk("add_exe_state", 32'(State), 32'd6);
      chk("add_exe_aluop", 32'(ALUOp), 32'd0);
      chk("add_exe_srcb", 32'(ALUSrcB), 32'd0);
      chk("add_exe_pcwre", 32'(PCWre), 32'd0);
      cyc();
      chk("add_wb_state", 32'(State), 32'd7);
      chk("add_wb_regwre", 32'(RegWre), 32'd1);
      chk("add_wb_regdst", 32'(RegDst), 32'd2);
      chk("add_wb_wrsrc", 32'(WrRegDSrc), 32'd1);
      chk("add_wb_dbsrc", 32'(DBDataSrc), 32'd0);
      chk("add_wb_pcwre", 32'(PCWre), 32'd1);
      chk("add_wb_pcsrc", 32'(PCSrc), 32'd0);
      cyc();
      chk("add_end_state", 32'(State), 32'd0);
`ifdef CTRL_PERF_EN
      chk("add_count", InstCount, 32'd1);
`endif

      // lw: 0 -> 1 -> 2 -> 3 -> 4 -> 0
      Op = 6'b110001;
      #1;
      cyc();
      chk("lw_id_state", 32'(State), 32'd1);
      cyc();
      chk("lw_exe_state", 32'(State), 32'd2);
      chk("lw_exe_srcb", 32'(ALUSrcB), 32'd1);
      chk("lw_exe_aluop", 32'(ALUOp), 32'd0);
      cyc();
      chk("lw_mem_state", 32'(State), 32'd3);
      chk("lw_mem_mrd", 32'(mRD), 32'd1);
      chk("lw_mem_mwr", 32'(mWR), 32'd0);
      chk("lw_mem_pcwre", 32'(PCWre), 32'd0);
      cyc();
      chk("lw_wb_state", 32'(State), 32'd4);
      chk("lw_wb_dbsrc", 32'(DBDataSrc), 32'd1);
      chk("lw_wb_regdst", 32'(RegDst), 32'd1);
      chk("lw_wb_regwre", 32'(RegWre), 32'd1);
      chk("lw_wb_pcwre", 32'(PCWre), 32'd1);
      cyc();
      chk("lw_end_state", 32'(State), 32'd0);

      // ori: zero-extended immediate, or, rt destination
      Op = 6'b010010;
      #1;
      cyc();
      cyc();
      chk("ori_exe_state", 32'(State), 32'd6);
      chk("ori_exe_aluop", 32'(ALUOp), 32'd3);
      chk("ori_exe_srcb", 32'(ALUSrcB), 32'd1);
      chk("ori_exe_extsel", 32'(ExtSel), 32'd0);
      cyc();
      chk("ori_wb_regdst", 32'(RegDst), 32'd1);
      chk("ori_wb_pcwre", 32'(PCWre), 32'd1);
      cyc();

      // sll: shamt on A
      Op = 6'b011000;
      #1;
      cyc();
      cyc();
      chk("sll_exe_srca", 32'(ALUSrcA), 32'd1);
      chk("sll_exe_aluop", 32'(ALUOp), 32'd2);
      chk("sll_exe_extsel", 32'(ExtSel), 32'd1);
      cyc();
      cyc();
      chk("sll_end_state", 32'(State), 32'd0);

      // branches, both polarities
      for (int i = 0; i < 6; i++) begin
         Op   = br_op[i];
         Zero = br_z[i];
         #1;
         cyc();
         chk($sformatf("br%0d_id_pcwre", i), 32'(PCWre), 32'd0);
         cyc();
         chk($sformatf("br%0d_state", i), 32'(State), 32'd5);
         chk($sformatf("br%0d_pcsrc", i), 32'(PCSrc), 32'(br_src[i]));
         chk($sformatf("br%0d_aluop", i), 32'(ALUOp), 32'(br_alu[i]));
         chk($sformatf("br%0d_pcwre", i), 32'(PCWre), 32'd1);
         cyc();
         chk($sformatf("br%0d_end", i), 32'(State), 32'd0);
      end
      Zero = 1'b0;

      // jal: links $31 with PC+4 in ID
      Op = 6'b111010;
      #1;
      cyc();
      chk("jal_id_state", 32'(State), 32'd1);
      chk("jal_id_pcsrc", 32'(PCSrc), 32'd3);
      chk("jal_id_regwre", 32'(RegWre), 32'd1);
      chk("jal_id_regdst", 32'(RegDst), 32'd0);
      chk("jal_id_wrsrc", 32'(WrRegDSrc), 32'd0);
      chk("jal_id_pcwre", 32'(PCWre), 32'd1);
      cyc();
      chk("jal_end_state", 32'(State), 32'd0);

      // jr
      Op = 6'b111001;
      #1;
      cyc();
      chk("jr_id_pcsrc", 32'(PCSrc), 32'd2);
      chk("jr_id_regwre", 32'(RegWre), 32'd0);
      chk("jr_id_pcwre", 32'(PCWre), 32'd1);
      cyc();

      // undefined opcode behaves as a nop
      Op = 6'b000111;
      #1;
      cyc();
      chk("undef_id_pcwre", 32'(PCWre), 32'd1);
      chk("undef_id_pcsrc", 32'(PCSrc), 32'd0);
      chk("undef_id_regwre", 32'(RegWre), 32'd0);
      cyc();
      chk("undef_end_state", 32'(State), 32'd0);

      // sw aborted by reset in MEM
      Op = 6'b110000;
      #1;
      cyc();
      cyc();
      cyc();
      chk("sw_mem_state", 32'(State), 32'd3);
      chk("sw_mem_mwr", 32'(mWR), 32'd1);
      Reset = 1'b1;
      #1;
      chk("sw_rst_mwr", 32'(mWR), 32'd0);
      chk("sw_rst_pcwre", 32'(PCWre), 32'd0);
      chk("sw_rst_insmem", 32'(InsMemRW), 32'd1);
      cyc();
      chk("sw_rst_state", 32'(State), 32'd0);
`ifdef CTRL_PERF_EN
      chk("sw_rst_count", InstCount, 32'd0);
`endif
      Reset = 1'b0;

      // halt: absorbing until reset
      Op = 6'b111111;
      #1;
      cyc();
      chk("halt_id_pcwre", 32'(PCWre), 32'd0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk($sformatf("halt%0d_state", i), 32'(State), 32'd8);
         chk($sformatf("halt%0d_pcwre", i), 32'(PCWre), 32'd0);
      end
      chk("halt_insmem", 32'(InsMemRW), 32'd0);
      Reset = 1'b1;
      #1;
      chk("halt_rst_insmem", 32'(InsMemRW), 32'd1);
      cyc();
      chk("halt_rst_state", 32'(State), 32'd0);
      Reset = 1'b0;
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle MIPS control unit that sits directly upstream of the ALU. A state register sequences each instruction through IF/ID/EXE/MEM/WB. Outputs are decoded from the state, the IR opcode and the ALU `Zero` flag. It drives the `ALUOp` select, operand muxes, register-file and memory enables, and PC update for the datapath.

## Interface
Parameters:
- `OP_W`, default 6: opcode width (IR[31:26]).
- `ST_W`, default 4: state register width.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Op`  in  6  opcode from the IR.
- `Zero`  in  1  ALU zero flag.
- `State`  out  4  current state, for debug.
- `ALUOp`  out  3  ALU function: 000 add, 001 sub, 010 sll, 011 or, 100 and, 110 signed lt.
- `ALUSrcA`  out  1  1 selects shamt as A.
- `ALUSrcB`  out  1  1 selects extended immediate as B.
- `ExtSel`  out  1  0 zero-extend, 1 sign-extend.
- `PCWre`  out  1  PC load enable.
- `PCSrc`  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- `InsMemRW`  out  1  instruction memory read.
- `IRWre`  out  1  IR load enable.
- `mRD`, `mWR`  out  1 each  data memory read and write.
- `RegWre`  out  1  register-file write enable.
- `RegDst`  out  2  00 $31, 01 rt, 10 rd.
- `WrRegDSrc`  out  1  0 PC+4, 1 DB bus.
- `DBDataSrc`  out  1  0 ALU result, 1 memory data.

## Operation
Opcodes:
- add 000000, sub 000001, addiu 000010
- andi 010000, and 010001, ori 010010, or 010011
- sll 011000, slti 100110
- sw 110000, lw 110001
- beq 110100, bne 110101, bltz 110110
- j 111000, jr 111001, jal 111010, halt 111111

States:
- IF 0000: `InsMemRW`=1, `IRWre`=1. Next state ID.
- ID 0001:
  - j/jal/jr: `PCWre`=1, `PCSrc`=11 (j, jal) or 10 (jr). jal also asserts `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0. Next state IF.
  - halt: next state HALT.
  - Undefined opcode: `PCWre`=1, `PCSrc`=00 (nop). Next state IF.
  - Otherwise: next state EXE_AL, EXE_BR or EXE_LS according to the opcode.
- EXE_AL 0110: `ALUOp` from the opcode. `ALUSrcA`=1 only for sll. `ALUSrcB`=1 for addiu/andi/ori/slti. Next state WB_AL.
- WB_AL 0111: `RegWre`=1, `WrRegDSrc`=1, `DBDataSrc`=0. `RegDst`=10 for R-type, 01 for immediates. `PCWre`=1, `PCSrc`=00. Next state IF.
- EXE_BR 0101: `ALUOp`=001 for beq/bne, 110 for bltz (B = $0). `PCWre`=1.
  - `PCSrc`=01 if taken, else 00.
  - Taken condition: beq when `Zero`=1, bne when `Zero`=0, bltz when `Zero`=0.
  - Next state IF.
- EXE_LS 0010: `ALUOp`=000, `ALUSrcB`=1. Next state MEM.
- MEM 0011:
  - sw: `mWR`=1, `PCWre`=1. Next state IF.
  - lw: `mRD`=1. Next state WB_LD.
- WB_LD 0100: `RegWre`=1, `RegDst`=01, `DBDataSrc`=1, `WrRegDSrc`=1, `PCWre`=1. Next state IF.
- HALT 1000: all enables 0. Absorbing until `Reset`.

Decode rules:
- `ExtSel`=0 for andi/ori, 1 otherwise.
- Any control output not listed for a state is 0.

## Timing
- State register updates on the rising edge of `CLK`. All other outputs are combinational from `State`, `Op` and `Zero`.
- Branch `PCSrc` depends on `Zero` within the EXE_BR cycle.
- Cycles per instruction: jump 2, branch 3, ALU 4, sw 4, lw 5.
- Exactly one `PCWre` pulse per retired instruction, asserted in its final cycle. Halt retires none.
- Reset:
  - While `Reset`=1, all outputs are forced to their IF values: `InsMemRW`=1, `IRWre`=0, all write enables 0, `PCWre`=0.
  - On the next edge, `State` becomes 0000.
  - A reset mid-instruction aborts it with no register or memory write in the reset cycle.
- `Op` must be stable from the end of IF until the instruction retires (the IR holds it).

## Configuration
- `CTRL_PERF_EN` defined: adds output `InstCount [31:0]`.
  - Reset value 0.
  - Increments on every edge where `PCWre`=1.
  - Wraps from 0xFFFFFFFF to 0.
- `CTRL_PERF_EN` undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `ctrl_pkg` holds:
  - the opcode constants;
  - the state encodings;
  - the `ALUOp` encodings (000–111, matching the ALU);
  - the `PCSrc` and `RegDst` encodings.
- Sub-module `ctrl_decode`: combinational `Op` → `ALUOp`, `ExtSel`, `ALUSrcA`, `ALUSrcB` and instruction class. It is instantiated once.

## Test plan
- Reset for 2 cycles, then `Op`=000000 (add) → `State` sequence 0000, 0001, 0110, 0111, 0000. `RegWre`=1 with `RegDst`=10 and `PCWre`=1 only in 0111.
- `Op`=110001 (lw) → 5 cycles. `mRD`=1 in 0011. `DBDataSrc`=1, `RegDst`=01 and `PCWre`=1 in 0100.
- `Op`=110100 (beq):
  - `Zero`=1 → `PCSrc`=01 in 0101.
  - `Zero`=0 → `PCSrc`=00.
  - Repeat for bne and bltz with the inverse taken polarity.
- `Op`=111010 (jal) → 2 cycles. In ID: `PCSrc`=11, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0.
- `Op`=111111 (halt) → `State`=1000 held for 20 cycles with `PCWre`=0. `Reset` → 0000 on the next edge.
- Assert `Reset` during MEM of sw → `mWR`=0 in that cycle and `State`=0000 on the next edge. With `CTRL_PERF_EN`, `InstCount` returns to 0.
